// File: rtl/execute_mc.sv
// Multi-cycle execute stage: 1-cycle ALU/branch ops, iterative mul/div, architectural HI/LO.
// Build option EXEC_DIV_EN: include the restoring divider (otherwise DIV/DIVU act as NOP).
module execute_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [2:0]            br_op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  br_taken,
    output logic [ADDR_WIDTH-1:0] br_target,
    output logic                  busy
);
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3,
                           OP_XOR = 5'd4,  OP_NOR = 5'd5,  OP_SLT = 5'd6,  OP_SLTU = 5'd7,
                           OP_SLL = 5'd8,  OP_SRL = 5'd9,  OP_SRA = 5'd10, OP_LUI = 5'd11,
                           OP_MULT = 5'd16, OP_MULTU = 5'd17, OP_DIV = 5'd18, OP_DIVU = 5'd19,
                           OP_MFHI = 5'd20, OP_MFLO = 5'd21, OP_MTHI = 5'd22, OP_MTLO = 5'd23;

    typedef enum logic [1:0] {IDLE, ITER, HOLD} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   hi, lo, acc, mq, opnd;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    is_div, neg_q, neg_r;

    logic                    accept, is_mul, is_divop, sgn;
    logic [DATA_WIDTH-1:0]   abs_a, abs_b, alu_res, acc_nx, mq_nx;
    logic [DATA_WIDTH:0]     mul_sum, div_trial;
    logic [2*DATA_WIDTH-1:0] prod;
    logic                    br_tk;
    logic [ADDR_WIDTH-1:0]   br_tgt;
    logic signed [17:0]      br_off;
    logic [31:0]             j_tgt;
    logic [SHW-1:0]          shamt;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
`ifdef EXEC_DIV_EN
    assign is_divop = (op == OP_DIV) || (op == OP_DIVU);
`else
    assign is_divop = 1'b0;
`endif
    assign sgn   = (op == OP_MULT) || (op == OP_DIV);
    assign abs_a = (sgn && src_a[DATA_WIDTH-1]) ? -src_a : src_a;
    assign abs_b = (sgn && src_b[DATA_WIDTH-1]) ? -src_b : src_b;
    assign shamt = src_a[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLT:  alu_res = DATA_WIDTH'($signed(src_a) < $signed(src_b));
            OP_SLTU: alu_res = DATA_WIDTH'(src_a < src_b);
            OP_SLL:  alu_res = src_b << shamt;
            OP_SRL:  alu_res = src_b >> shamt;
            OP_SRA:  alu_res = $signed(src_b) >>> shamt;
            OP_LUI:  alu_res = src_b << (DATA_WIDTH / 2);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_MTHI: alu_res = src_a;
            OP_MTLO: alu_res = src_a;
            default: alu_res = '0;
        endcase
    end

    assign br_off = $signed({imm, 2'b00});
    assign j_tgt  = {pc_plus4[ADDR_WIDTH-1 -: 4], target, 2'b00};

    always_comb begin
        case (br_op)
            3'd1:    br_tk = (src_a == src_b);
            3'd2:    br_tk = (src_a != src_b);
            3'd3:    br_tk = src_a[DATA_WIDTH-1];
            3'd4:    br_tk = !src_a[DATA_WIDTH-1];
            3'd5:    br_tk = src_a[DATA_WIDTH-1] || (src_a == '0);
            3'd6:    br_tk = !src_a[DATA_WIDTH-1] && (src_a != '0);
            3'd7:    br_tk = 1'b1;
            default: br_tk = 1'b0;
        endcase
        br_tgt = (br_op == 3'd7) ? ADDR_WIDTH'(j_tgt) : pc_plus4 + ADDR_WIDTH'(br_off);
    end

    // One iteration: shift-add (acc:mq is the running product) or restoring divide (acc = remainder).
    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        div_trial = {acc, mq[DATA_WIDTH-1]} - {1'b0, opnd};
        if (is_div) begin
            if (!div_trial[DATA_WIDTH]) begin
                acc_nx = div_trial[DATA_WIDTH-1:0];
                mq_nx  = {mq[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = {acc[DATA_WIDTH-2:0], mq[DATA_WIDTH-1]};
                mq_nx  = {mq[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx = mul_sum[DATA_WIDTH:1];
            mq_nx  = {mul_sum[0], mq[DATA_WIDTH-1:1]};
        end
        prod = neg_q ? -{acc_nx, mq_nx} : {acc_nx, mq_nx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
            busy      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            acc       <= '0;
            mq        <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        br_taken  <= br_tk;
                        br_target <= br_tgt;
                        if (is_divop && src_b == '0) begin
                            hi        <= src_a;
                            lo        <= '1;
                            result    <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else if (is_mul || is_divop) begin
                            state     <= ITER;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            cnt       <= CNT_WIDTH'(DATA_WIDTH);
                            is_div    <= is_divop;
                            acc       <= '0;
                            mq        <= abs_a;
                            opnd      <= abs_b;
                            neg_q     <= sgn && (src_a[DATA_WIDTH-1] ^ src_b[DATA_WIDTH-1]);
                            neg_r     <= sgn && src_a[DATA_WIDTH-1];
                        end else begin
                            result    <= alu_res;
                            out_valid <= 1'b1;
                            if (op == OP_MTHI) hi <= src_a;
                            if (op == OP_MTLO) lo <= src_a;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                ITER: begin
                    acc <= acc_nx;
                    mq  <= mq_nx;
                    cnt <= cnt - 1'b1;
                    // Final step and HI/LO writeback share the last ITER cycle.
                    if (cnt == CNT_WIDTH'(1)) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= '0;
                        state     <= HOLD;
                        if (is_div) begin
                            hi <= neg_r ? -acc_nx : acc_nx;
                            lo <= neg_q ? -mq_nx : mq_nx;
                        end else begin
                            {hi, lo} <= prod;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
